// File: rtl/spi_slave_regfile_if.sv
// Bus bundle between an SPI master and the register-file slave:
// serial lines, select, debug read port and frame status.
interface spi_slave_regfile_if #(
    parameter int ADDR_W = 3
) ();
    logic              ss;
    logic              in;
    logic              out;
    logic [ADDR_W-1:0] dbg_addr;
    logic [7:0]        dbg_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        last_cmd;

    modport slave (
        input  ss,
        input  in,
        input  dbg_addr,
        output out,
        output dbg_data,
        output busy,
        output done,
        output err,
        output last_cmd
    );

    modport master (
        output ss,
        output in,
        output dbg_addr,
        input  out,
        input  dbg_data,
        input  busy,
        input  done,
        input  err,
        input  last_cmd
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI slave in front of a small register file: command byte then data byte, both LSB first.
// Bit 7 of the command selects read (1) or write (0); low ADDR_W bits select the register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for ss low; the edge that sees it starts the frame
// CMD     | shifting in 8 command bits
// DATA_RX | shifting in 8 data bits, written to reg[addr] on the 8th
// DATA_TX | shifting out snapshot of reg[addr], LSB first
// HOLD    | frame finished, out=0, waiting for ss high before next frame
module spi_slave_regfile #(
    parameter int ADDR_W = 3
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    spi_slave_regfile_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] DATA_RX = 3'd2;
    localparam logic [2:0] DATA_TX = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    logic [2:0]        state;
    logic [2:0]        cnt;
    logic [6:0]        shift_sr;
    logic [7:0]        shift_next;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_data;
    logic              out_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        last_cmd_q;
    logic [7:0]        regs [DEPTH];

    // Byte as it stands including the bit sampled on this edge.
    assign shift_next = {bus.in, shift_sr};

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_sr   <= '0;
            addr_q     <= '0;
            tx_data    <= '0;
            out_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_cmd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'(i * 17);
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    out_q <= 1'b0;
                    if (!bus.ss) begin
                        state <= CMD;
                        cnt   <= '0;
                    end
                end
                CMD: begin
                    if (bus.ss) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                        out_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        shift_sr <= shift_next[7:1];
                        cnt      <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            last_cmd_q <= shift_next;
                            addr_q     <= shift_next[ADDR_W-1:0];
                            cnt        <= '0;
                            if (shift_next[7]) begin
                                // Snapshot so a concurrent write cannot tear the read.
                                tx_data <= regs[shift_next[ADDR_W-1:0]];
                                state   <= DATA_TX;
                            end else begin
                                state   <= DATA_RX;
                            end
                        end
                    end
                end
                DATA_RX: begin
                    if (bus.ss) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                        out_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        shift_sr <= shift_next[7:1];
                        cnt      <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            regs[addr_q] <= shift_next;
                            done_q       <= 1'b1;
                            cnt          <= '0;
                            state        <= HOLD;
                        end
                    end
                end
                DATA_TX: begin
                    if (bus.ss) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                        out_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        out_q <= tx_data[cnt];
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            done_q <= 1'b1;
                            cnt    <= '0;
                            state  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    out_q <= 1'b0;
                    if (bus.ss) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    out_q <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.out      = out_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.last_cmd = last_cmd_q;
    assign bus.busy     = (state == CMD) || (state == DATA_RX) || (state == DATA_TX);
    assign bus.dbg_data = regs[bus.dbg_addr];
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: reset pattern, write, read, abort,
// back-to-back frames and asynchronous reset in the middle of a write.
module tb_spi_slave_regfile;
    logic sclk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    spi_slave_regfile_if #(.ADDR_W(3)) bus ();

    spi_slave_regfile #(.ADDR_W(3)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Drive at the falling edge, return 1 time unit after the next rising edge.
    task automatic clk_bit(input logic s, input logic b);
        @(negedge sclk);
        bus.ss = s;
        bus.in = b;
        @(posedge sclk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        clk_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) clk_bit(1'b0, c[i]);
    endtask

    task automatic test_reset();
        logic [7:0] exp_tbl [8];
        exp_tbl = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        rst_n = 1'b0;
        bus.ss = 1'b1;
        bus.in = 1'b0;
        bus.dbg_addr = '0;
        repeat (3) @(posedge sclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (bus.dbg_data !== exp_tbl[i]) begin
                n_fail++;
                $display("FAIL reset_reg[%0d]: got %h expected %h", i, bus.dbg_data, exp_tbl[i]);
            end
        end
        n_checks++;
        if ({bus.out, bus.busy, bus.done, bus.err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got out/busy/done/err=%b expected 0000",
                     {bus.out, bus.busy, bus.done, bus.err});
        end
        n_checks++;
        if (bus.last_cmd !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_last_cmd: got %h expected 00", bus.last_cmd);
        end
        @(negedge sclk);
        rst_n = 1'b1;
        clk_bit(1'b1, 1'b0);
    endtask

    task automatic test_write();
        logic [7:0] d;
        d = 8'hA5;
        bus.dbg_addr = 3'd5;
        send_cmd(8'h05);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy: got %b expected 1", bus.busy);
        end
        for (int i = 0; i < 7; i++) clk_bit(1'b0, d[i]);
        n_checks++;
        if (bus.dbg_data !== 8'h55 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL write_before_e16: got reg=%h done=%b expected 55 0", bus.dbg_data, bus.done);
        end
        clk_bit(1'b0, d[7]);
        n_checks++;
        if (bus.dbg_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_reg: got %h expected a5", bus.dbg_data);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: got done/err/busy=%b%b%b expected 100", bus.done, bus.err, bus.busy);
        end
        n_checks++;
        if (bus.last_cmd !== 8'h05) begin
            n_fail++;
            $display("FAIL write_last_cmd: got %h expected 05", bus.last_cmd);
        end
        clk_bit(1'b0, 1'b0);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done_width: got %b expected 0", bus.done);
        end
        clk_bit(1'b1, 1'b0);
    endtask

    task automatic test_read();
        logic [7:0] exp_d;
        exp_d = 8'h33;
        bus.dbg_addr = 3'd3;
        send_cmd(8'h83);
        for (int k = 0; k < 8; k++) begin
            clk_bit(1'b0, 1'b1);
            n_checks++;
            if (bus.out !== exp_d[k]) begin
                n_fail++;
                $display("FAIL read_bit[%0d]: got %b expected %b", k, bus.out, exp_d[k]);
            end
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL read_done: got %b expected 1", bus.done);
        end
        clk_bit(1'b0, 1'b0);
        n_checks++;
        if (bus.out !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after: got out=%b done=%b expected 0 0", bus.out, bus.done);
        end
        n_checks++;
        if (bus.dbg_data !== 8'h33 || bus.last_cmd !== 8'h83) begin
            n_fail++;
            $display("FAIL read_unchanged: got reg=%h last_cmd=%h expected 33 83", bus.dbg_data, bus.last_cmd);
        end
        clk_bit(1'b1, 1'b0);
    endtask

    task automatic test_abort();
        logic [7:0] d;
        bus.dbg_addr = 3'd2;
        send_cmd(8'h02);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, 1'b1);
        clk_bit(1'b1, 1'b0);
        n_checks++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse: got err/done/busy/out=%b%b%b%b expected 1000",
                     bus.err, bus.done, bus.busy, bus.out);
        end
        clk_bit(1'b1, 1'b0);
        n_checks++;
        if (bus.err !== 1'b0 || bus.dbg_data !== 8'h22) begin
            n_fail++;
            $display("FAIL abort_after: got err=%b reg=%h expected 0 22", bus.err, bus.dbg_data);
        end
        d = 8'h5A;
        send_cmd(8'h02);
        for (int i = 0; i < 8; i++) clk_bit(1'b0, d[i]);
        n_checks++;
        if (bus.dbg_data !== 8'h5A || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_recover: got reg=%h done=%b expected 5a 1", bus.dbg_data, bus.done);
        end
        clk_bit(1'b1, 1'b0);
        clk_bit(1'b0, 1'b0);
        clk_bit(1'b0, 1'b0);
        clk_bit(1'b0, 1'b1);
        clk_bit(1'b0, 1'b1);
        clk_bit(1'b1, 1'b0);
        n_checks++;
        if (bus.err !== 1'b1 || bus.last_cmd !== 8'h02) begin
            n_fail++;
            $display("FAIL abort_in_cmd: got err=%b last_cmd=%h expected 1 02", bus.err, bus.last_cmd);
        end
        clk_bit(1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [7:0] rd;
        logic       seen_busy;
        logic       seen_done;
        d = 8'h3C;
        rd = '0;
        bus.dbg_addr = 3'd7;
        send_cmd(8'h07);
        for (int i = 0; i < 8; i++) clk_bit(1'b0, d[i]);
        n_checks++;
        if (bus.dbg_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_write: got %h expected 3c", bus.dbg_data);
        end
        clk_bit(1'b1, 1'b0);
        send_cmd(8'h87);
        for (int k = 0; k < 8; k++) begin
            clk_bit(1'b0, 1'b0);
            rd[k] = bus.out;
        end
        n_checks++;
        if (rd !== 8'h3C || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_read: got %h done=%b expected 3c 1", rd, bus.done);
        end
        seen_busy = 1'b0;
        seen_done = 1'b0;
        bus.dbg_addr = 3'd6;
        d = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            clk_bit(1'b0, (i == 0 || i > 8) ? d[0] : 1'b0);
            seen_busy |= bus.busy;
            seen_done |= (i > 0) ? bus.done : 1'b0;
        end
        n_checks++;
        if (seen_busy !== 1'b0 || seen_done !== 1'b0 || bus.dbg_data !== 8'h66) begin
            n_fail++;
            $display("FAIL b2b_no_rise: got busy=%b done=%b reg6=%h expected 0 0 66",
                     seen_busy, seen_done, bus.dbg_data);
        end
        clk_bit(1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        bus.dbg_addr = 3'd4;
        send_cmd(8'h04);
        for (int i = 0; i < 4; i++) clk_bit(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out, bus.busy, bus.done, bus.err} !== 4'b0000 || bus.last_cmd !== 8'h00) begin
            n_fail++;
            $display("FAIL async_rst_outputs: got out/busy/done/err=%b last_cmd=%h expected 0000 00",
                     {bus.out, bus.busy, bus.done, bus.err}, bus.last_cmd);
        end
        n_checks++;
        if (bus.dbg_data !== 8'h44) begin
            n_fail++;
            $display("FAIL async_rst_target: got %h expected 44", bus.dbg_data);
        end
        bus.dbg_addr = 3'd7;
        #1;
        n_checks++;
        if (bus.dbg_data !== 8'h77) begin
            n_fail++;
            $display("FAIL async_rst_restore: got %h expected 77", bus.dbg_data);
        end
        @(negedge sclk);
        bus.ss = 1'b1;
        rst_n = 1'b1;
        repeat (12) clk_bit(1'b1, 1'b1);
        bus.dbg_addr = 3'd4;
        #1;
        n_checks++;
        if (bus.dbg_data !== 8'h44 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_no_write: got reg=%h busy=%b expected 44 0", bus.dbg_data, bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.ss   = 1'b1;
        bus.in   = 1'b0;
        bus.dbg_addr = '0;
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
